// File: rtl/node_pkg.sv
// Shared types and helpers for the neuron node: FSM states, mode encodings and
// a saturating adder that clamps a wide sum into an ACC_W-bit signed range.
package node_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        FIRE = 2'd2
    } state_e;

    localparam logic MODE_THRESH = 1'b0;
    localparam logic MODE_IAF    = 1'b1;

    localparam int SAT_W = 32;

    // Adds two sign-extended operands and clamps the result to an acc_w-bit signed range.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             acc_w
    );
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sum = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi  = (33'sd1 <<< (acc_w - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (acc_w - 1));
        if (sum > hi) begin
            return hi[SAT_W-1:0];
        end else if (sum < lo) begin
            return lo[SAT_W-1:0];
        end else begin
            return sum[SAT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/node_mac.sv
// One multiply-accumulate step: unsigned input times signed weight, added to the
// accumulator with saturation. Purely combinational.
module node_mac #(
    parameter int IN_W  = 2,
    parameter int WGT_W = 4,
    parameter int ACC_W = 11
) (
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic        [IN_W-1:0]  x_i,
    input  logic signed [WGT_W-1:0] w_i,
    output logic signed [ACC_W-1:0] acc_o
);
    import node_pkg::*;

    logic signed [IN_W+WGT_W:0] prod_d;

    // Zero-extend the input so it multiplies as a non-negative signed value.
    always_comb begin
        prod_d = $signed({1'b0, x_i}) * w_i;
        acc_o  = ACC_W'(sat_add(SAT_W'(acc_i), SAT_W'(prod_d), ACC_W));
    end

endmodule

// File: rtl/node_param.sv
// Parametrised neuron node: serial weighted sum of NUM_IN inputs compared against a
// threshold, with a per-sample mode and a leaky integrate-and-fire mode.
module node_param #(
    parameter int NUM_IN   = 5,
    parameter int IN_W     = 2,
    parameter int WGT_W    = 4,
    parameter int WGT_INIT = 1,
    parameter int ACC_W    = IN_W + WGT_W + $clog2(NUM_IN) + 2,
    parameter int THRESH   = 4,
    parameter int LEAK_SH  = 2,
    localparam int AW      = $clog2(NUM_IN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [NUM_IN*IN_W-1:0] in_bus,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   wgt_we,
    input  logic [AW-1:0]          wgt_addr,
    input  logic [WGT_W-1:0]       wgt_data,
    output logic                   wgt_err,
    output logic                   out,
    output logic                   out_valid,
    output logic [ACC_W-1:0]       acc_out
);
    import node_pkg::*;

    localparam logic signed [ACC_W-1:0] THRESH_C = ACC_W'(THRESH);
    localparam logic signed [WGT_W-1:0] WINIT_C  = WGT_W'(WGT_INIT);

    state_e                   state_q;
    logic [AW-1:0]            ch_q;
    logic signed [WGT_W-1:0]  w_q [NUM_IN];
    logic [NUM_IN*IN_W-1:0]   in_q;
    logic                     mode_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_out_q;
    logic                     in_ready_q;
    logic                     out_q;
    logic                     out_valid_q;
    logic                     wgt_err_q;

    logic [IN_W-1:0]          x_d;
    logic signed [WGT_W-1:0]  w_d;
    logic signed [ACC_W-1:0]  acc_mac_d;
    logic signed [ACC_W-1:0]  leak_d;
    logic signed [ACC_W-1:0]  fire_sub_d;
    logic                     wgt_ok_d;

    // Operand selection for the current channel, leak and reset-by-subtraction values.
    always_comb begin
        x_d        = in_q[ch_q*IN_W +: IN_W];
        w_d        = w_q[ch_q];
        leak_d     = acc_q - (acc_q >>> LEAK_SH);
        fire_sub_d = ACC_W'(sat_add(SAT_W'(acc_q), SAT_W'(-THRESH), ACC_W));
        wgt_ok_d   = (state_q == IDLE) && (32'(wgt_addr) < NUM_IN);
    end

    node_mac #(
        .IN_W  (IN_W),
        .WGT_W (WGT_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .acc_i (acc_q),
        .x_i   (x_d),
        .w_i   (w_d),
        .acc_o (acc_mac_d)
    );

    // Node FSM, weight file and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            in_q        <= '0;
            mode_q      <= MODE_THRESH;
            acc_q       <= '0;
            acc_out_q   <= '0;
            in_ready_q  <= 1'b1;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            wgt_err_q   <= 1'b0;
            for (int k = 0; k < NUM_IN; k++) begin
                w_q[k] <= WINIT_C;
            end
        end else begin
            out_valid_q <= 1'b0;
            wgt_err_q   <= 1'b0;
            if (wgt_we) begin
                if (wgt_ok_d) begin
                    w_q[wgt_addr] <= wgt_data;
                end else begin
                    wgt_err_q <= 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_q       <= in_bus;
                        mode_q     <= mode;
                        ch_q       <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= MAC;
                        acc_q      <= (mode == MODE_IAF) ? leak_d : '0;
                    end
                end
                MAC: begin
                    acc_q <= acc_mac_d;
                    if (ch_q == AW'(NUM_IN - 1)) begin
                        state_q <= FIRE;
                    end else begin
                        ch_q <= ch_q + AW'(1);
                    end
                end
                FIRE: begin
                    out_q       <= (acc_q >= THRESH_C);
                    acc_out_q   <= acc_q;
                    out_valid_q <= 1'b1;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                    // Integrate-and-fire keeps the residue above threshold after firing.
                    if ((mode_q == MODE_IAF) && (acc_q >= THRESH_C)) begin
                        acc_q <= fire_sub_d;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign acc_out   = acc_out_q;
    assign wgt_err   = wgt_err_q;

endmodule
